bus_trace_hex_dumper: RTL

Downstream stage of the bus-cycle capture buffer in the serial bus debugger. When a dump is requested, it reads captured bus-cycle records out of the trace RAM one at a time. Each record is formatted as a fixed-length ASCII hex line and streamed byte-by-byte to the UART transmitter over a valid/ready handshake. The block is a pure formatter and sequencer: no record storage beyond a single latched record.

---
 rtl/bus_trace_hex_dumper.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/bus_trace_hex_dumper.sv
// Reads bus-cycle records from the trace RAM and streams each one as a 22-byte ASCII hex line
// ("AAAAAAAA DDDDDDDD RE\r\n") to the UART over a valid/ready handshake.
module bus_trace_hex_dumper #(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dump_start,
  input  logic [ADDR_BITS:0]   rec_count,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd,
  input  logic [31:0]          mem_addr_word,
  input  logic [31:0]          mem_data_word,
  input  logic [1:0]           mem_flags,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StWait   = 3'd2;
  localparam logic [2:0] StEmit   = 3'd3;
  localparam logic [2:0] StFinish = 3'd4;

  localparam logic [4:0] LastChar = 5'd21;

  logic [2:0]         state_q, state_d;
  logic               start_prev_q;
  logic [ADDR_BITS:0] cnt_q, cnt_d;
  logic [ADDR_BITS:0] idx_q, idx_d;
  logic [ADDR_BITS:0] idx_inc;
  logic [4:0]         char_q, char_d;
  logic [31:0]        rec_addr_q, rec_addr_d;
  logic [31:0]        rec_data_q, rec_data_d;
  logic [1:0]         rec_flags_q, rec_flags_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               start_edge;
  logic [7:0]         char_byte;
  logic [2:0]         addr_nib;
  logic [2:0]         data_nib;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  assign start_edge = dump_start & ~start_prev_q;
  assign idx_inc    = idx_q + 1'b1;

  // Chars 0..7 select address nibbles MSB first; chars 9..16 do the same for data.
  assign addr_nib = 3'd7 - char_q[2:0];
  assign data_nib = 3'd7 - (char_q[2:0] - 3'd1);

  always_comb begin
    char_byte = 8'h00;
    if (char_q <= 5'd7) begin
      char_byte = hex_char(rec_addr_q[{addr_nib, 2'b00} +: 4]);
    end else if (char_q == 5'd8 || char_q == 5'd17) begin
      char_byte = 8'h20;
    end else if (char_q <= 5'd16) begin
      char_byte = hex_char(rec_data_q[{data_nib, 2'b00} +: 4]);
    end else if (char_q == 5'd18) begin
      char_byte = rec_flags_q[0] ? 8'h52 : 8'h57;
    end else if (char_q == 5'd19) begin
      char_byte = rec_flags_q[1] ? 8'h45 : 8'h2D;
    end else if (char_q == 5'd20) begin
      char_byte = 8'h0D;
    end else begin
      char_byte = 8'h0A;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    char_d      = char_q;
    rec_addr_d  = rec_addr_q;
    rec_data_d  = rec_data_q;
    rec_flags_d = rec_flags_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_edge) begin
          cnt_d   = rec_count;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = (rec_count == '0) ? StFinish : StFetch;
        end
      end
      StFetch: state_d = StWait;
      StWait: begin
        rec_addr_d  = mem_addr_word;
        rec_data_d  = mem_data_word;
        rec_flags_d = mem_flags;
        char_d      = 5'd0;
        state_d     = StEmit;
      end
      StEmit: begin
        if (!tx_valid_q) begin
          tx_data_d  = char_byte;
          tx_valid_d = 1'b1;
        end else if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (char_q == LastChar) begin
            idx_d   = idx_inc;
            state_d = (idx_inc == cnt_q) ? StFinish : StFetch;
          end else begin
            char_d = char_q + 5'd1;
          end
        end
      end
      StFinish: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      start_prev_q <= 1'b1;
      cnt_q        <= '0;
      idx_q        <= '0;
      char_q       <= 5'd0;
      rec_addr_q   <= 32'h0;
      rec_data_q   <= 32'h0;
      rec_flags_q  <= 2'b00;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= dump_start;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      char_q       <= char_d;
      rec_addr_q   <= rec_addr_d;
      rec_data_q   <= rec_data_d;
      rec_flags_q  <= rec_flags_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign mem_addr = idx_q[ADDR_BITS-1:0];
  assign mem_rd   = (state_q == StFetch);
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
